// File: rtl/v_arb_pkg.sv
// Shared vector defines plus the VRAM arbiter's default widths, MAX_LOCK default and FSM state enum.
package v_arb_pkg;

  localparam int unsigned V_VLEN   = 512;
  localparam int unsigned V_ELEN   = 32;
  localparam int unsigned V_LANES  = V_VLEN / V_ELEN;

  localparam int unsigned N_REQ    = 2;
  localparam int unsigned REQ_VMEM = 0;
  localparam int unsigned REQ_HOST = 1;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = V_VLEN;
  localparam int unsigned DEF_MAX_LOCK = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/v_rr_pick2.sv
// Two-way round-robin pick: ptr_i names the favoured requester when both are valid.
module v_rr_pick2
  import v_arb_pkg::*;
(
  input  logic [N_REQ-1:0] valid_i,
  input  logic             ptr_i,
  output logic [N_REQ-1:0] gnt_c
);

  assign gnt_c[0] = valid_i[0] & (~valid_i[1] | ~ptr_i);
  assign gnt_c[1] = valid_i[1] & (~valid_i[0] |  ptr_i);

endmodule

// File: rtl/v_vram_arb.sv
// VRAM port arbiter between the vector memory stage (req0) and the host/DMA loader (req1).
// Define V_VRAM_ARB_LOCK_EN to enable locked bursts (OWN0/OWN1 states, lock_cnt).
module v_vram_arb
  import v_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [DATA_W-1:0] req0_wmask,
  output logic              req0_gnt,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [DATA_W-1:0] req1_wmask,
  output logic              req1_gnt,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              vram_r_ena,
  output logic [ADDR_W-1:0] vram_r_addr,
  input  logic [DATA_W-1:0] vram_r_data,
  output logic              vram_w_ena,
  output logic [ADDR_W-1:0] vram_w_addr,
  output logic [DATA_W-1:0] vram_w_data,
  output logic [DATA_W-1:0] vram_w_mask
);

  logic [N_REQ-1:0]  valid_c;
  logic [N_REQ-1:0]  pick_valid;
  logic [N_REQ-1:0]  gnt;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] sel_wmask;
  logic              ptr_q, ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;

  // Gating with rst keeps every combinational output low during reset.
  assign valid_c = {req1_valid, req0_valid} & {N_REQ{~rst}};

`ifdef V_VRAM_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0]  cnt_inc;

  // An owner excludes the other requester from arbitration.
  always_comb begin
    pick_valid = valid_c;
    case (state_q)
      ST_OWN0: pick_valid = {1'b0, valid_c[0]};
      ST_OWN1: pick_valid = {valid_c[1], 1'b0};
      default: pick_valid = valid_c;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    cnt_inc    = (lock_cnt_q == CNT_W'(MAX_LOCK)) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        lock_cnt_d = '0;
        if (gnt[0] && req0_lock) begin
          lock_cnt_d = CNT_W'(1);
          if (MAX_LOCK > 1) state_d = ST_OWN0;
        end else if (gnt[1] && req1_lock) begin
          lock_cnt_d = CNT_W'(1);
          if (MAX_LOCK > 1) state_d = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!req0_valid || !req0_lock) begin
          state_d = ST_IDLE;
        end else begin
          lock_cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_LOCK)) state_d = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!req1_valid || !req1_lock) begin
          state_d = ST_IDLE;
        end else begin
          lock_cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_LOCK)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  logic unused_lock;

  assign pick_valid  = valid_c;
  assign unused_lock = req0_lock ^ req1_lock;
`endif

  v_rr_pick2 u_pick (
    .valid_i (pick_valid),
    .ptr_i   (ptr_q),
    .gnt_c   (gnt)
  );

  assign any_gnt = |gnt;

  always_comb begin
    sel_we    = gnt[1] ? req1_we    : req0_we;
    sel_addr  = gnt[1] ? req1_addr  : req0_addr;
    sel_wdata = gnt[1] ? req1_wdata : req0_wdata;
    sel_wmask = gnt[1] ? req1_wmask : req0_wmask;
  end

  assign req0_gnt    = gnt[0];
  assign req1_gnt    = gnt[1];
  assign vram_r_ena  = any_gnt & ~sel_we;
  assign vram_r_addr = (any_gnt && !sel_we) ? sel_addr : '0;
  assign vram_w_ena  = any_gnt & sel_we;
  assign vram_w_addr = (any_gnt && sel_we) ? sel_addr  : '0;
  assign vram_w_data = (any_gnt && sel_we) ? sel_wdata : '0;
  assign vram_w_mask = (any_gnt && sel_we) ? sel_wmask : '0;

  // Last granted requester drops to lowest priority; pointer holds when idle.
  always_comb begin
    ptr_d      = ptr_q;
    rd_pend_d  = any_gnt & ~sel_we;
    rd_owner_d = gnt[1];
    if (gnt[0])      ptr_d = 1'b1;
    else if (gnt[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign rsp0_valid = rd_pend_q & ~rd_owner_q;
  assign rsp1_valid = rd_pend_q &  rd_owner_q;
  assign rsp0_data  = rsp0_valid ? vram_r_data : '0;
  assign rsp1_data  = rsp1_valid ? vram_r_data : '0;

endmodule

// File: tb/tb_v_vram_arb.sv
// Self-checking bench for v_vram_arb: directed scenarios plus random traffic against a reference model.
module tb_v_vram_arb;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 512;
  localparam int unsigned MAX_LOCK = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_we, req0_lock;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata, req0_wmask;
  logic              req0_gnt, rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic              req1_valid, req1_we, req1_lock;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata, req1_wmask;
  logic              req1_gnt, rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;
  logic              vram_r_ena, vram_w_ena;
  logic [ADDR_W-1:0] vram_r_addr, vram_w_addr;
  logic [DATA_W-1:0] vram_r_data, vram_w_data, vram_w_mask;

  v_vram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
    .req0_gnt(req0_gnt), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
    .req1_gnt(req1_gnt), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .vram_r_ena(vram_r_ena), .vram_r_addr(vram_r_addr), .vram_r_data(vram_r_data),
    .vram_w_ena(vram_w_ena), .vram_w_addr(vram_w_addr),
    .vram_w_data(vram_w_data), .vram_w_mask(vram_w_mask)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: favoured requester, current lock owner (-1 none), grants in the run, pending read.
  int                fav, owner, run;
  bit                pend_v;
  int                pend_o;
  logic [ADDR_W-1:0] pend_a;
  bit                cap_ena;
  logic [ADDR_W-1:0] cap_addr;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b required %0b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    return {16{h}};
  endfunction

  function automatic int pick();
    bit v0, v1;
    v0 = req0_valid;
    v1 = req1_valid;
    if (rst) return -1;
    if (owner == 0) v1 = 1'b0;
    if (owner == 1) v0 = 1'b0;
    if (v0 && v1) return fav;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    fav    = 0;
    owner  = -1;
    run    = 0;
    pend_v = 1'b0;
    pend_o = 0;
    pend_a = '0;
  endtask

  task automatic check_outputs();
    int                g;
    bit                we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd, wm;
    g  = pick();
    we = (g == 1) ? req1_we : req0_we;
    a  = (g == 1) ? req1_addr : req0_addr;
    wd = (g == 1) ? req1_wdata : req0_wdata;
    wm = (g == 1) ? req1_wmask : req0_wmask;
    chk1("gnt0", req0_gnt, g == 0);
    chk1("gnt1", req1_gnt, g == 1);
    chk1("r_ena", vram_r_ena, g >= 0 && !we);
    chka("r_addr", vram_r_addr, (g >= 0 && !we) ? a : '0);
    chk1("w_ena", vram_w_ena, g >= 0 && we);
    chka("w_addr", vram_w_addr, (g >= 0 && we) ? a : '0);
    chkw("w_data", vram_w_data, (g >= 0 && we) ? wd : '0);
    chkw("w_mask", vram_w_mask, (g >= 0 && we) ? wm : '0);
    chk1("rsp0_valid", rsp0_valid, pend_v && pend_o == 0);
    chk1("rsp1_valid", rsp1_valid, pend_v && pend_o == 1);
    chkw("rsp0_data", rsp0_data, (pend_v && pend_o == 0) ? mem_word(pend_a) : '0);
    chkw("rsp1_data", rsp1_data, (pend_v && pend_o == 1) ? mem_word(pend_a) : '0);
  endtask

  task automatic model_edge();
    int g;
    bit vg, lg;
    g = pick();
    if (rst) begin
      model_reset();
      return;
    end
    pend_v = (g >= 0) && !((g == 1) ? req1_we : req0_we);
    pend_o = g;
    pend_a = (g == 1) ? req1_addr : req0_addr;
`ifdef V_VRAM_ARB_LOCK_EN
    if (owner < 0) begin
      lg = (g == 1) ? req1_lock : req0_lock;
      if (g >= 0 && lg) begin
        run   = 1;
        owner = (run >= int'(MAX_LOCK)) ? -1 : g;
      end
    end else begin
      vg = (owner == 1) ? req1_valid : req0_valid;
      lg = (owner == 1) ? req1_lock : req0_lock;
      if (!vg || !lg) begin
        owner = -1;
      end else begin
        run++;
        if (run >= int'(MAX_LOCK)) owner = -1;
      end
    end
`else
    vg = 1'b0;
    lg = 1'b0;
`endif
    if (g >= 0) fav = 1 - g;
  endtask

  // Called just after a falling edge with inputs set: check, then advance one cycle.
  task automatic settle();
    #1;
    check_outputs();
    cap_ena  = vram_r_ena;
    cap_addr = vram_r_addr;
  endtask

  task automatic advance();
    @(posedge clk);
    vram_r_data = cap_ena ? mem_word(cap_addr) : {16{$urandom()}};
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_we = 1'b0; req0_lock = 1'b0; req0_addr = '0;
    req0_wdata = '0;   req0_wmask = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_lock = 1'b0; req1_addr = '0;
    req1_wdata = '0;   req1_wmask = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    settle();
    advance();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    vram_r_data = '0;
    cap_ena = 1'b0;
    cap_addr = '0;
    model_reset();
    idle_inputs();
    @(negedge clk);
    // Outputs stay low during reset even with both requesters asking.
    req0_valid = 1'b1; req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h10;
    settle();
    chk1("rst_gnt0", req0_gnt, 1'b0);
    chk1("rst_wena", vram_w_ena, 1'b0);
    advance();
    rst = 1'b0;

    // Two reads back to back after reset.
    idle_inputs();
    req0_valid = 1'b1; req0_addr = 32'h100;
    req1_valid = 1'b1; req1_addr = 32'h200;
    settle();
    chk1("rd2_c0_gnt0", req0_gnt, 1'b1);
    advance();
    req0_valid = 1'b0;
    settle();
    chk1("rd2_c1_gnt1", req1_gnt, 1'b1);
    chk1("rd2_c1_rsp0", rsp0_valid, 1'b1);
    chkw("rd2_c1_data0", rsp0_data, mem_word(32'h100));
    advance();
    req1_valid = 1'b0;
    settle();
    chk1("rd2_c2_rsp1", rsp1_valid, 1'b1);
    chkw("rd2_c2_data1", rsp1_data, mem_word(32'h200));
    advance();

    // Host write passes straight through and never responds.
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h40;
    req1_wdata = {64{8'hA5}}; req1_wmask = '1;
    settle();
    chk1("wr_ena", vram_w_ena, 1'b1);
    chka("wr_addr", vram_w_addr, 32'h40);
    chkw("wr_data", vram_w_data, {64{8'hA5}});
    chkw("wr_mask", vram_w_mask, {DATA_W{1'b1}});
    advance();
    idle_inputs();
    settle();
    chk1("wr_no_rsp1", rsp1_valid, 1'b0);
    advance();

`ifdef V_VRAM_ARB_LOCK_EN
    // Lock held 20 cycles: 16 grants, forced release to req1, then req0 again.
    do_reset();
    req0_valid = 1'b1; req0_lock = 1'b1; req0_addr = 32'h300;
    req1_valid = 1'b1; req1_addr = 32'h400;
    for (int i = 0; i < 20; i++) begin
      settle();
      chk1($sformatf("lock_c%0d_gnt0", i), req0_gnt, i != 16);
      chk1($sformatf("lock_c%0d_gnt1", i), req1_gnt, i == 16);
      advance();
    end

    // Lock dropped after three locked grants: release grant to req0, then req1.
    idle_inputs();
    do_reset();
    req0_valid = 1'b1; req0_addr = 32'h500;
    req1_valid = 1'b1; req1_addr = 32'h600;
    for (int i = 0; i < 5; i++) begin
      req0_lock = (i < 3);
      settle();
      chk1($sformatf("drop_c%0d_gnt1", i), req1_gnt, i == 4);
      advance();
    end
`else
    // Locks ignored: strict alternation.
    do_reset();
    req0_valid = 1'b1; req0_lock = 1'b1; req0_addr = 32'h700;
    req1_valid = 1'b1; req1_lock = 1'b1; req1_addr = 32'h800;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk1($sformatf("alt_c%0d_gnt0", i), req0_gnt, (i % 2) == 0);
      advance();
    end
`endif

    // Reset right after a read grant drops the response and restores the pointer.
    idle_inputs();
    do_reset();
    req0_valid = 1'b1; req0_addr = 32'h80;
    settle();
    chk1("rstrd_gnt0", req0_gnt, 1'b1);
    @(posedge clk);
    vram_r_data = mem_word(cap_addr);
    model_edge();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    chk1("rstrd_rsp0_in_rst", rsp0_valid, 1'b0);
    @(negedge clk);
    settle();
    advance();
    rst = 1'b0;
    req0_valid = 1'b0;
    settle();
    chk1("rstrd_rsp0_after", rsp0_valid, 1'b0);
    advance();
    req0_valid = 1'b1; req1_valid = 1'b1; req1_addr = 32'h90;
    settle();
    chk1("rstrd_ptr0", req0_gnt, 1'b1);
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 9) < 7);
      req0_we    = ($urandom_range(0, 9) < 3);
      req0_lock  = ($urandom_range(0, 9) < 4);
      req0_addr  = $urandom();
      req0_wdata = {16{$urandom()}};
      req0_wmask = {16{$urandom()}};
      req1_valid = ($urandom_range(0, 9) < 7);
      req1_we    = ($urandom_range(0, 9) < 3);
      req1_lock  = ($urandom_range(0, 9) < 4);
      req1_addr  = $urandom();
      req1_wdata = {16{$urandom()}};
      req1_wmask = {16{$urandom()}};
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/v_vram_arb.md
V_VRAM_ARB -- requirements
Module: v_vram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: VRAM address width.
REQ-002 SHALL have parameter DATA_W, default 512: VRAM data and mask width.
REQ-003 SHALL have parameter MAX_LOCK, default 16: maximum consecutive locked grants to one requester.
REQ-004 SHALL have port clk, input, 1: single clock; all state on the rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have, per requester n in {0,1}, these ports: reqN_valid in 1, reqN_we in 1, reqN_lock in 1, reqN_addr in ADDR_W, reqN_wdata in DATA_W, reqN_wmask in DATA_W.
REQ-007 SHALL have, per requester n in {0,1}, these ports: reqN_gnt out 1, rspN_valid out 1, rspN_data out DATA_W.
REQ-008 SHALL have VRAM-side ports: vram_r_ena out 1, vram_r_addr out ADDR_W, vram_r_data in DATA_W, vram_w_ena out 1, vram_w_addr out ADDR_W, vram_w_data out DATA_W, vram_w_mask out DATA_W.
REQ-009 SHALL designate requester 0 as the vector memory stage and requester 1 as the host/DMA loader.

Function
REQ-010 SHALL grant at most one requester per cycle: reqN_gnt is combinational and asserted only when reqN_valid=1.
REQ-011 SHALL, in the same cycle, drive the VRAM port from the granted requester: we=1 gives vram_w_ena=1 with addr, wdata and wmask; we=0 gives vram_r_ena=1 with addr.
REQ-012 SHALL hold all vram_* enables at 0, and addr/data/mask at 0, when there is no grant.
REQ-013 SHALL treat VRAM reads as 1-cycle latency: for a read granted in cycle N, rspN_valid=1 and rspN_data=vram_r_data in cycle N+1, tracked by registered rd_pend and rd_owner.
REQ-014 SHALL hold rspN_data at 0 whenever rspN_valid=0, and SHALL never assert a write response.
REQ-015 SHALL arbitrate round-robin using a 1-bit pointer: the last granted requester gets lowest priority next cycle, and the pointer updates only on a grant.
REQ-016 SHALL, when only one requester is valid, grant it regardless of the pointer (no idle bubble).
REQ-017 SHALL implement an FSM with states IDLE, OWN0 and OWN1.
REQ-018 SHALL, in IDLE, perform round-robin arbitration; a grant with reqN_lock=1 moves the FSM to OWNn and loads lock_cnt=1.
REQ-019 SHALL, in OWNn, grant only requester n; the other requester is stalled even when valid.
REQ-020 SHALL, in OWNn, increment lock_cnt on each grant to n.
REQ-021 SHALL leave OWNn for IDLE when reqn_lock=0 or reqn_valid=0, or on the grant where lock_cnt reaches MAX_LOCK.
REQ-022 SHALL, on a forced release (lock_cnt reached MAX_LOCK) with the other requester valid, grant the other requester next cycle: the pointer is set to favour it.
REQ-023 SHALL give valid-without-lock in OWNn the same treatment as lock deassertion: that grant is issued and the FSM returns to IDLE.
REQ-024 SHALL saturate lock_cnt and never wrap; its width is clog2(MAX_LOCK+1).

Reset
REQ-025 SHALL, on rst=1 (asynchronous), set FSM=IDLE, pointer=0 (requester 0 favoured), lock_cnt=0 and rd_pend=0.
REQ-026 SHALL drive all outputs to 0 while reset is asserted.
REQ-027 SHALL drop a read in flight when reset is asserted: no rspN_valid is issued after reset release.

Configuration
REQ-028 SHALL, with macro V_VRAM_ARB_LOCK_EN defined, implement reqN_lock, the OWN0/OWN1 states and lock_cnt as above.
REQ-029 SHALL, without V_VRAM_ARB_LOCK_EN, keep the reqN_lock ports but ignore them, stay permanently in IDLE (pure round-robin) and omit lock_cnt.

Structure
REQ-030 SHALL place the FSM state enum, default widths and the MAX_LOCK default in a shared package v_arb_pkg, alongside the existing vector defines.
REQ-031 SHALL factor the 2-input round-robin priority selection into one sub-module, v_rr_pick2 (inputs: valids, pointer; output: one-hot grant).

Verification
REQ-032 SHALL verify: both valid reads in cycle 0 after reset, no lock -> gnt0 in cycle 0, gnt1 in cycle 1, rsp0_valid in cycle 1, rsp1_valid in cycle 2, data equal to the VRAM contents at the respective addresses.
REQ-033 SHALL verify: req1 write, addr=0x40, wmask all-ones, data=0xA5.. -> vram_w_ena=1 in the same cycle with identical addr/data/mask, and no rsp1_valid.
REQ-034 SHALL verify: req0 locked for 20 cycles while req1 is continuously valid, MAX_LOCK=16 -> 16 consecutive gnt0, gnt1 in cycle 17, then gnt0 resumes.
REQ-035 SHALL verify: req0 lock dropped after 3 grants while req1 is waiting -> gnt1 in the next cycle, FSM in IDLE.
REQ-036 SHALL verify: rst asserted in the cycle after a read grant -> rsp0_valid never asserted, all outputs 0 immediately, pointer=0 after release.
REQ-037 SHALL verify: build without V_VRAM_ARB_LOCK_EN, both requesters continuously valid with lock=1 -> strict alternation gnt0, gnt1, gnt0, ...
